// File: rtl/bcd_display_pkg.sv
// Shared scan-state encoding and seven-segment constants for the two-digit display driver.
// Segment constants are active-high {g,f,e,d,c,b,a}; polarity is applied at the output register.
package bcd_display_pkg;

  localparam logic [1:0] ST_DEAD_T  = 2'd0;
  localparam logic [1:0] ST_ONES_ON = 2'd1;
  localparam logic [1:0] ST_DEAD_O  = 2'd2;
  localparam logic [1:0] ST_TENS_ON = 2'd3;

  typedef enum logic [1:0] {
    DEAD_T  = ST_DEAD_T,
    ONES_ON = ST_ONES_ON,
    DEAD_O  = ST_DEAD_O,
    TENS_ON = ST_TENS_ON
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;

  // Converts an active-high pattern to the pin level for the chosen polarity.
  function automatic logic [6:0] seg_to_pins(input logic [6:0] seg_hi, input bit active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD to seven-segment decoder: 0-9 as digits, F blank, A-E as a dash.
module bcd_seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // NOTE: the default assignment ahead of the case guarantees every path drives seg, so no latch is inferred.
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'h0:      seg = SEG_DIGIT_0;
      4'h1:      seg = SEG_DIGIT_1;
      4'h2:      seg = SEG_DIGIT_2;
      4'h3:      seg = SEG_DIGIT_3;
      4'h4:      seg = SEG_DIGIT_4;
      4'h5:      seg = SEG_DIGIT_5;
      4'h6:      seg = SEG_DIGIT_6;
      4'h7:      seg = SEG_DIGIT_7;
      4'h8:      seg = SEG_DIGIT_8;
      4'h9:      seg = SEG_DIGIT_9;
      BCD_BLANK: seg = SEG_BLANK;
      default:   seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment scanner with dead time between slots and
// once-per-frame digit capture so a changing count never tears the display.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int ON_CYCLES      = 50000,
  parameter int DEAD_CYCLES    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int T_MAX = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int TW    = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = seg_to_pins(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam logic [1:0] AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0] AN_ONES = AN_ACTIVE_LOW ? 2'b10 : 2'b01;
  localparam logic [1:0] AN_TENS = AN_ACTIVE_LOW ? 2'b01 : 2'b10;

  scan_state_t   state;
  logic [TW-1:0] timer;
  logic [3:0]    tens_q;
  logic [3:0]    ones_q;

  logic          slot_end;
  logic [3:0]    dec_code;
  logic [6:0]    dec_seg;

  always_comb begin
    slot_end = 1'b0;
    case (state)
      ONES_ON, TENS_ON: slot_end = (timer == ON_LAST);
      default:          slot_end = (timer == DEAD_LAST);
    endcase
  end

  // Select the digit for the slot being entered. The ones slot decodes the live
  // input because it is captured on that same edge, keeping seg in step with an.
  always_comb begin
    dec_code = BCD_BLANK;
    case (state)
      DEAD_T:  dec_code = ones;
      DEAD_O:  dec_code = tens_q;
      default: dec_code = BCD_BLANK;
    endcase
  end

  bcd_seg7_decode u_decode (
    .code (dec_code),
    .seg  (dec_seg)
  );

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DEAD_T;
      timer      <= '0;
      tens_q     <= BCD_BLANK;
      ones_q     <= BCD_BLANK;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (slot_end) begin
        timer <= '0;
        case (state)
          DEAD_T: begin
            state      <= ONES_ON;
            tens_q     <= tens;
            ones_q     <= ones;
            frame_done <= 1'b1;
            an         <= AN_ONES;
            seg        <= seg_to_pins(dec_seg, SEG_ACTIVE_LOW);
          end
          ONES_ON: begin
            state <= DEAD_O;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
          end
          DEAD_O: begin
            state <= TENS_ON;
            an    <= AN_TENS;
            seg   <= seg_to_pins(dec_seg, SEG_ACTIVE_LOW);
          end
          default: begin
            state <= DEAD_T;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
          end
        endcase
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // ones_q only records the captured pair; the ones slot is decoded from the live input on capture.
  logic unused_ones_q;
  assign unused_ones_q = ^ones_q;

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed two-digit seven-segment driver that consumes the tens/ones BCD digit pair from the project's 01–99 counter, including its blanked-tens code 4'hF. It decodes each digit to segments and time-multiplexes one shared segment bus across two common-anode digits. Dead time between slots suppresses ghosting. Digit values are latched once per frame, so a count that changes mid-scan never tears the display.

## Interface
- ON_CYCLES, 50000: clock cycles each digit is lit; minimum 1.
- DEAD_CYCLES, 1000: clock cycles with all digits off between slots; minimum 1.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0.
- AN_ACTIVE_LOW, 1: 1 means a selected digit drives 0.
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- tens  input  4  tens digit: 0–9 shown, 4'hF blank, 4'hA–4'hE shown as dash.
- ones  input  4  ones digit, same coding as tens.
- seg  output  7  segments {g,f,e,d,c,b,a}, registered.
- an  output  2  digit enables, an[0]=ones and an[1]=tens, registered.
- frame_done  output  1  one-cycle pulse on the cycle new digits are latched.

## Operation
- States: DEAD_T (after tens), ONES_ON, DEAD_O (after ones), TENS_ON. Fixed cycle DEAD_T → ONES_ON → DEAD_O → TENS_ON → DEAD_T.
- Slot timer: counts each state's cycles and clears on every transition.
  - ON states last exactly ON_CYCLES edges.
  - DEAD states last exactly DEAD_CYCLES edges.
  - Timer width is clog2(max(ON_CYCLES, DEAD_CYCLES)) + 1.
- Capture:
  - On the DEAD_T → ONES_ON edge, tens and ones are sampled into internal latches and frame_done is 1 for that cycle.
  - No other edge samples the inputs.
- ONES_ON: ones digit enabled; seg = decode(latched ones).
- TENS_ON: tens digit enabled; seg = decode(latched tens).
- DEAD states: both digits disabled; seg all-off.
- Decode, active-high form before polarity:
  - 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A–E = 7'h40 (dash).
  - F = 7'h00 (blank).
- Polarity: seg is inverted when SEG_ACTIVE_LOW=1; an is inverted when AN_ACTIVE_LOW=1.
  - With active-low defaults, "all off" is seg=7'h7F and an=2'b11.
- A blank digit still occupies its full slot with its anode enabled and segments off. Scan timing never depends on data.
- Input changes outside the capture edge have no visible effect until the next frame.

## Timing
- Reset (asynchronous, while reset_n=0):
  - state=DEAD_T, timer=0, both latched digits=4'hF.
  - an=all-off, seg=all-off, frame_done=0.
- After release:
  - First capture and first lit digit occur on the DEAD_CYCLES-th rising edge.
  - seg and an change on that same edge, with no extra output latency.
- Frame period is exactly 2·(ON_CYCLES + DEAD_CYCLES) cycles. frame_done pulses once per frame, never two cycles in a row.
- an and seg are both registered and switch on the same edge. An enabled digit never shows the other digit's segments for any cycle.
- Reset mid-frame forces the reset values immediately (asynchronous) and discards the latched digits. The scan restarts from DEAD_T after release.
- Timer roll-over:
  - The transition edge loads the timer to 0; the timer never wraps.
  - For ON_CYCLES=1 or DEAD_CYCLES=1, the state lasts exactly one cycle.

## Structure
- Package bcd_display_pkg:
  - state encoding localparams (2-bit);
  - SEG_BLANK=7'h00, SEG_DASH=7'h40, BCD_BLANK=4'hF;
  - the ten digit segment constants.
- Sub-module bcd_seg7_decode: purely combinational, 4-bit code in, 7-bit active-high segments out. Instantiated once, fed by a mux of the latched digits; polarity is applied in the parent before the output register.
- Everything else (FSM, timer, latches, output registers) lives in bcd_display_scan.

## Test plan
All scenarios use ON_CYCLES=4, DEAD_CYCLES=2, active-low defaults.
- Reset values: hold reset_n=0 → seg=7'h7F, an=2'b11, frame_done=0.
- First frame: release with tens=4'hF, ones=4'h1.
  - Edge 2: frame_done=1, an=2'b10, seg=7'h79 for 4 cycles.
  - Then 2 cycles of an=2'b11.
  - Then an=2'b01, seg=7'h7F (blanked tens) for 4 cycles.
- No tearing: tens=1, ones=9; change to tens=2, ones=0 mid-ONES_ON.
  - The remainder of the frame shows 9 then 1 (seg 7'h10 / 7'h79).
  - The next frame shows 0 then 2 (7'h40 / 7'h24).
- Period check: run 5 frames → frame_done pulses exactly every 12 cycles.
- Error code: ones=4'hB → ones slot seg=7'h3F (dash).
- Async reset mid-TENS_ON: assert reset_n between edges.
  - Outputs go all-off without waiting for a clock edge.
  - After release, the first lit digit appears 2 edges later with freshly captured values.
